// File: rtl/range_stream_driver_if.sv
// Handshake bundle between a sample host and range_stream_driver.
// The master modport is the host side; the slave modport is the driver.
interface range_stream_driver_if #(
  parameter int WIDTH = 8
);
  logic             load;
  logic [WIDTH-1:0] data_in;
  logic             start;
  logic [WIDTH-1:0] data_out;
  logic             go;
  logic             finish;
  logic [WIDTH-1:0] range_in;
  logic             error_in;
  logic             busy;
  logic             full;
  logic             done;
  logic [WIDTH-1:0] range_out;
  logic             mismatch;

  modport master (
    output load, data_in, start, range_in, error_in,
    input  data_out, go, finish, busy, full, done, range_out, mismatch
  );

  modport slave (
    input  load, data_in, start, range_in, error_in,
    output data_out, go, finish, busy, full, done, range_out, mismatch
  );
endinterface

// File: rtl/range_stream_driver.sv
// Buffers a burst of samples, streams it to a range finder and captures the reported range.
// Define RANGE_STREAM_CHECK_EN to cross-check range_in against the loaded samples' max-min.
module range_stream_driver #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input logic                  clock,
  input logic                  reset,
  range_stream_driver_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  typedef enum logic [1:0] {IDLE, SEND, FIN, CAPTURE} state_t;

  state_t                       state, state_nxt;
  logic [CW-1:0]                count;
  logic [IW-1:0]                idx;
  logic [DEPTH-1:0][WIDTH-1:0]  mem;
  logic [WIDTH-1:0]             data_out;
  logic                         go, finish, done;
  logic                         push, launch, last, chk_fail;
  logic [WIDTH-1:0]             range_q;
  logic                         mismatch_q;

  assign last = ({1'b0, idx} == count - CW'(1));

  always_comb begin
    state_nxt = state;
    data_out  = '0;
    go        = 1'b0;
    finish    = 1'b0;
    done      = 1'b0;
    push      = 1'b0;
    launch    = 1'b0;
    case (state)
      IDLE: begin
        // a coincident start takes priority; the load is dropped
        push   = bus.load && !bus.start && (count < CW'(DEPTH));
        launch = bus.start && (count != '0);
        if (launch) state_nxt = SEND;
      end
      SEND: begin
        data_out = mem[idx];
        go       = (idx == '0);
        if (last) state_nxt = FIN;
      end
      FIN: begin
        finish    = 1'b1;
        state_nxt = CAPTURE;
      end
      CAPTURE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      idx        <= '0;
      mem        <= '0;
      range_q    <= '0;
      mismatch_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push) begin
        mem[count[IW-1:0]] <= bus.data_in;
        count              <= count + CW'(1);
      end
      if (launch) idx <= '0;
      else if (state == SEND && !last) idx <= idx + IW'(1);
      if (state == CAPTURE) begin
        range_q    <= bus.range_in;
        mismatch_q <= chk_fail;
        count      <= '0;
      end
    end
  end

`ifdef RANGE_STREAM_CHECK_EN
  logic [WIDTH-1:0] mn, mx;

  // min/max restart whenever the buffer empties (capture or reset)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mn <= '1;
      mx <= '0;
    end else if (state == CAPTURE) begin
      mn <= '1;
      mx <= '0;
    end else if (push) begin
      if (bus.data_in < mn) mn <= bus.data_in;
      if (bus.data_in > mx) mx <= bus.data_in;
    end
  end

  assign chk_fail = bus.error_in || (bus.range_in != WIDTH'(mx - mn));
`else
  assign chk_fail = bus.error_in;
`endif

  assign bus.data_out  = data_out;
  assign bus.go        = go;
  assign bus.finish    = finish;
  assign bus.done      = done;
  assign bus.busy      = (state != IDLE);
  assign bus.full      = (count == CW'(DEPTH));
  assign bus.range_out = range_q;
  assign bus.mismatch  = mismatch_q;
endmodule

// File: tb/tb_range_stream_driver.sv
// Directed bench for range_stream_driver: burst timing, buffer limits, checking and reset.
module tb_range_stream_driver;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

`ifdef RANGE_STREAM_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [WIDTH-1:0] vec [DEPTH];

  range_stream_driver_if #(.WIDTH(WIDTH)) bus ();

  range_stream_driver #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_val(input logic [WIDTH-1:0] v);
    bus.load    = 1'b1;
    bus.data_in = v;
    tick();
    bus.load    = 1'b0;
  endtask

  // start, then check n samples, finish and done on their fixed cycles
  task automatic send_check(input int n);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("go[%0d]", i), 32'(bus.go), 32'(i == 0));
      chk($sformatf("data[%0d]", i), 32'(bus.data_out), 32'(vec[i]));
      chk($sformatf("busy[%0d]", i), 32'(bus.busy), 32'd1);
      tick();
    end
    chk("finish", 32'(bus.finish), 32'd1);
    chk("fin_data", 32'(bus.data_out), 32'd0);
    tick();
    bus.load = 1'b0;
    chk("done", 32'(bus.done), 32'd1);
    chk("done_fin", 32'(bus.finish), 32'd0);
    tick();
    chk("done_end", 32'(bus.done), 32'd0);
    chk("idle", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bus.load = 0; bus.data_in = 0; bus.start = 0; bus.range_in = 0; bus.error_in = 0;
    tick();
    tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_go", 32'(bus.go), 32'd0);
    chk("rst_rng", 32'(bus.range_out), 32'd0);
    chk("rst_mis", 32'(bus.mismatch), 32'd0);
    reset = 1'b0;
    tick();

    // basic burst 3,9,5 with range 6
    bus.range_in = 8'd6;
    load_val(8'd3); load_val(8'd9); load_val(8'd5);
    vec[0] = 8'd3; vec[1] = 8'd9; vec[2] = 8'd5;
    send_check(3);
    chk("b_rng", 32'(bus.range_out), 32'd6);
    chk("b_mis", 32'(bus.mismatch), 32'd0);

    // same burst, wrong range; loads held during the burst must be dropped
    bus.range_in = 8'd7;
    load_val(8'd3); load_val(8'd9); load_val(8'd5);
    bus.load = 1'b1; bus.data_in = 8'd77;
    send_check(3);
    chk("c_rng", 32'(bus.range_out), 32'd7);
    chk("c_mis", 32'(bus.mismatch), 32'(CHK));

    // empty start: nothing buffered
    chk("e_full", 32'(bus.full), 32'd0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("e_busy", 32'(bus.busy), 32'd0);
    chk("e_go", 32'(bus.go), 32'd0);
    tick();
    chk("e_done", 32'(bus.done), 32'd0);

    // single sample with an error flag
    bus.range_in = 8'd0; bus.error_in = 1'b1;
    load_val(8'd42);
    vec[0] = 8'd42;
    send_check(1);
    chk("s_rng", 32'(bus.range_out), 32'd0);
    chk("s_mis", 32'(bus.mismatch), 32'd1);
    bus.error_in = 1'b0;

    // full buffer: 9th load ignored
    bus.range_in = 8'd7;
    for (int i = 1; i <= 8; i++) begin
      load_val(8'(i));
      vec[i-1] = 8'(i);
    end
    chk("f_full8", 32'(bus.full), 32'd1);
    load_val(8'd9);
    chk("f_full9", 32'(bus.full), 32'd1);
    send_check(8);
    chk("f_rng", 32'(bus.range_out), 32'd7);
    chk("f_mis", 32'(bus.mismatch), 32'd0);
    chk("f_clr", 32'(bus.full), 32'd0);

    // reset on the second sample of a burst
    bus.error_in = 1'b1;
    load_val(8'd1); load_val(8'd2); load_val(8'd3);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("r_go0", 32'(bus.go), 32'd1);
    tick();
    chk("r_d1", 32'(bus.data_out), 32'd2);
    reset = 1'b1;
    #1;
    chk("r_data", 32'(bus.data_out), 32'd0);
    chk("r_busy", 32'(bus.busy), 32'd0);
    chk("r_go", 32'(bus.go), 32'd0);
    chk("r_fin", 32'(bus.finish), 32'd0);
    chk("r_done", 32'(bus.done), 32'd0);
    chk("r_rng", 32'(bus.range_out), 32'd0);
    chk("r_mis", 32'(bus.mismatch), 32'd0);
    tick();
    reset = 1'b0;
    bus.error_in = 1'b0;
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("r_nogo", 32'(bus.go), 32'd0);
    chk("r_nobusy", 32'(bus.busy), 32'd0);
    tick();
    tick();
    chk("r_nodone", 32'(bus.done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
